// File: rtl/deserializer_if.sv
// deserializer_if: serial line and framing controls in, received word and status pulses out
interface deserializer_if #(parameter int DWIDTH = 8);
  logic              rx_in;
  logic              par_en;
  logic              par_typ;
  logic [DWIDTH-1:0] p_data;
  logic              data_valid;
  logic              par_err;
  logic              stp_err;
  logic              rx_busy;
  modport master (output rx_in, par_en, par_typ, input p_data, data_valid, par_err, stp_err, rx_busy);
  modport slave  (input rx_in, par_en, par_typ, output p_data, data_valid, par_err, stp_err, rx_busy);
endinterface

// File: rtl/deserializer.sv
// deserializer: oversampled async serial receiver with 2-of-3 bit voting and optional parity
module deserializer #(
  parameter int DWIDTH = 8,
  parameter int OVS    = 8
) (
  input logic          clk,
  input logic          rst,
  deserializer_if.slave bus
);
  localparam int EW = $clog2(OVS);
  localparam int BW = $clog2(DWIDTH);
  localparam logic [EW-1:0] S0   = EW'(OVS/2-1);
  localparam logic [EW-1:0] S1   = EW'(OVS/2);
  localparam logic [EW-1:0] S2   = EW'(OVS/2+1);
  localparam logic [EW-1:0] LAST = EW'(OVS-1);
  localparam logic [BW-1:0] BLAST = BW'(DWIDTH-1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic              rx_s;
  logic [EW-1:0]     edge_q, edge_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DWIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
  logic [1:0]        smp_q, smp_d;
  logic              pen_q, pen_d, ptyp_q, ptyp_d, perr_q, perr_d;
  logic              valid_q, valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d, busy_q;
  logic              maj, at_vote, at_last, stop_now;
  assign rx_s    = sync_q[1];
  assign at_vote = edge_q == S2;
  assign at_last = edge_q == LAST;
  // third sample is the live rx_s, so the vote resolves in the S2 cycle itself
  assign maj     = (smp_q[0] & smp_q[1]) | (rx_s & (smp_q[0] | smp_q[1]));
  assign smp_d   = (edge_q == S0 || edge_q == S1) ? {smp_q[0], rx_s} : smp_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      smp_q     <= '0;
      pen_q     <= 1'b0;
      ptyp_q    <= 1'b0;
      perr_q    <= 1'b0;
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], bus.rx_in};
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      smp_q     <= smp_d;
      pen_q     <= pen_d;
      ptyp_q    <= ptyp_d;
      perr_q    <= perr_d;
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      busy_q    <= state_d != IDLE;
    end
  end
  always_comb begin
    state_d = state_q;
    edge_d  = at_last ? '0 : edge_q + EW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        // the cycle that first sees the line low counts as edge 0 of the start bit
        state_d = rx_s ? IDLE : START;
        edge_d  = rx_s ? '0 : EW'(1);
      end
      START: begin
        if (at_vote && maj) begin
          state_d = IDLE;
          edge_d  = '0;
        end else begin
          if (at_vote) begin
            pen_d  = bus.par_en;
            ptyp_d = bus.par_typ;
            perr_d = 1'b0;
          end
          if (at_last) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (at_vote) shift_d = {maj, shift_q[DWIDTH-1:1]};
        if (at_last) begin
          bit_d   = bit_q == BLAST ? '0 : bit_q + BW'(1);
          state_d = bit_q != BLAST ? DATA : pen_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_vote) perr_d = (^shift_q ^ maj) != ptyp_q;
        if (at_last) state_d = STOP;
      end
      STOP: begin
        if (at_vote) begin
          state_d = maj ? IDLE : WAIT_HIGH;
          edge_d  = '0;
        end
      end
      WAIT_HIGH: begin
        state_d = rx_s ? IDLE : WAIT_HIGH;
        edge_d  = '0;
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
      end
    endcase
  end
  always_comb begin
    stop_now  = state_q == STOP && at_vote;
    valid_d   = stop_now && maj && !perr_q;
    par_err_d = stop_now && perr_q;
    stp_err_d = stop_now && !maj;
    p_data_d  = valid_d ? shift_q : p_data_q;
  end
  assign bus.p_data     = p_data_q;
  assign bus.data_valid = valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.rx_busy    = busy_q;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed and random frames checked against a frame-level reference model
module tb_deserializer;
  localparam int OVS = 8;
  logic       clk = 1'b0;
  logic       rst;
  int         n_chk = 0;
  int         n_fail = 0;
  int         pe_cnt = 0;
  int         se_cnt = 0;
  logic [7:0] dv_q[$];
  logic [7:0] model_pd = '0;
  deserializer_if #(.DWIDTH(8)) bus();
  deserializer #(.DWIDTH(8), .OVS(OVS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.data_valid) dv_q.push_back(bus.p_data);
    if (bus.par_err) pe_cnt++;
    if (bus.stp_err) se_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_bit(input logic b, input int n);
    bus.rx_in = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic drive_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input logic pbit, input logic sval, input int slen);
    bus.par_en  = pen;
    bus.par_typ = ptyp;
    drive_bit(1'b0, OVS);
    chk("busy_start", 32'(bus.rx_busy), 32'd1);
    // controls wander after the start bit; the receiver must keep the values seen at start
    bus.par_en  = 1'($urandom);
    bus.par_typ = 1'($urandom);
    for (int i = 0; i < 8; i++) drive_bit(d[i], OVS);
    if (pen) drive_bit(pbit, OVS);
    drive_bit(sval, slen);
    chk("busy_stop", 32'(bus.rx_busy), 32'(!sval));
    bus.rx_in = 1'b1;
  endtask
  task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                           input logic pbit, input logic sval, input int slen, input int gap);
    int   dv0, pe0, se0;
    logic exp_pe, exp_se, exp_dv;
    dv0 = dv_q.size();
    pe0 = pe_cnt;
    se0 = se_cnt;
    drive_frame(d, pen, ptyp, pbit, sval, slen);
    drive_bit(1'b1, gap);
    exp_pe = pen && ((^d ^ pbit) != ptyp);
    exp_se = !sval;
    exp_dv = !exp_pe && !exp_se;
    if (exp_dv) model_pd = d;
    chk("dv_count", 32'(dv_q.size() - dv0), 32'(exp_dv));
    if (exp_dv && dv_q.size() > dv0) chk("dv_data", 32'(dv_q[dv0]), 32'(d));
    chk("par_err", 32'(pe_cnt - pe0), 32'(exp_pe));
    chk("stp_err", 32'(se_cnt - se0), 32'(exp_se));
    chk("p_data", 32'(bus.p_data), 32'(model_pd));
    chk("busy_idle", 32'(bus.rx_busy), 32'd0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_pdata"}, 32'(bus.p_data), 32'd0);
    chk({tag, "_dv"}, 32'(bus.data_valid), 32'd0);
    chk({tag, "_pe"}, 32'(bus.par_err), 32'd0);
    chk({tag, "_se"}, 32'(bus.stp_err), 32'd0);
    chk({tag, "_busy"}, 32'(bus.rx_busy), 32'd0);
  endtask
  initial begin
    int       dv0, pe0, se0;
    logic     sval;
    bus.rx_in   = 1'b1;
    bus.par_en  = 1'b0;
    bus.par_typ = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    repeat (OVS) @(negedge clk);
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, OVS, 2*OVS);
    run_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, OVS, 2*OVS);
    run_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, OVS, 2*OVS);
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 40, 2*OVS);
    dv0 = dv_q.size();
    pe0 = pe_cnt;
    se0 = se_cnt;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 3*OVS);
    chk("glitch_dv", 32'(dv_q.size() - dv0), 32'd0);
    chk("glitch_err", 32'(pe_cnt - pe0 + se_cnt - se0), 32'd0);
    chk("glitch_pdata", 32'(bus.p_data), 32'(model_pd));
    chk("glitch_busy", 32'(bus.rx_busy), 32'd0);
    dv0 = dv_q.size();
    drive_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, OVS);
    drive_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, OVS);
    drive_bit(1'b1, 2*OVS);
    model_pd = 8'hFF;
    chk("b2b_count", 32'(dv_q.size() - dv0), 32'd2);
    if (dv_q.size() >= dv0 + 2) begin
      chk("b2b_first", 32'(dv_q[dv0]), 32'h00);
      chk("b2b_second", 32'(dv_q[dv0+1]), 32'hFF);
    end
    chk("b2b_pdata", 32'(bus.p_data), 32'(model_pd));
    drive_bit(1'b0, OVS);
    drive_bit(1'b1, OVS);
    drive_bit(1'b0, OVS);
    drive_bit(1'b1, OVS/2);
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    model_pd = '0;
    drive_bit(1'b1, 2*OVS);
    chk_zero("inrst");
    rst = 1'b1;
    drive_bit(1'b1, 2*OVS);
    chk_zero("postrst");
    run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, OVS, 2*OVS);
    for (int n = 0; n < 40; n++) begin
      sval = $urandom_range(0, 4) != 0;
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), sval,
                sval ? OVS : int'($urandom_range(OVS, 5*OVS)), int'($urandom_range(OVS, 3*OVS)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: number of data bits per frame, 5..9.
REQ-002 SHALL have parameter OVS, default 8: clk cycles per bit period, even, >= 4.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rx_in, input, 1: asynchronous serial line, idle high.
REQ-006 SHALL have port par_en, input, 1: 1 = frame carries a parity bit after the data bits.
REQ-007 SHALL have port par_typ, input, 1: 0 = even parity, 1 = odd parity.
REQ-008 SHALL have port p_data, output, DWIDTH: last good received word, LSB first on the line.
REQ-009 SHALL have port data_valid, output, 1: one-cycle pulse when p_data is updated.
REQ-010 SHALL have port par_err, output, 1: one-cycle pulse on parity mismatch.
REQ-011 SHALL have port stp_err, output, 1: one-cycle pulse when the stop bit is sampled low.
REQ-012 SHALL have port rx_busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL pass rx_in through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 SHALL run edge counter edge_cnt 0..OVS-1 per bit; wraps to 0 and advances the bit at OVS-1.
REQ-016 IDLE: on the first cycle rx_s = 0, SHALL enter START with edge_cnt = 0 in that cycle.
REQ-017 SHALL sample rx_s at edge_cnt = OVS/2-1, OVS/2 and OVS/2+1; the bit value is the 2-of-3 majority.
REQ-018 START: majority 1 (glitch) SHALL return to IDLE at edge_cnt = OVS/2+1, with no error flag.
REQ-019 START: majority 0 SHALL latch par_en and par_typ; mid-frame changes to those inputs SHALL be ignored.
REQ-020 DATA: SHALL shift DWIDTH bits LSB first into an internal register, not into p_data.
REQ-021 After DATA, SHALL enter PARITY if the latched par_en = 1, else STOP.
REQ-022 PARITY: mismatch is XOR(data bits, parity bit) != latched par_typ.
REQ-023 STOP: at edge_cnt = OVS/2+1, SHALL resolve the frame in the same cycle: good frame (stop = 1, parity ok or disabled) loads p_data and pulses data_valid on the next clock.
REQ-024 Parity mismatch SHALL pulse par_err and suppress data_valid; a stop bit of 0 SHALL pulse stp_err and suppress data_valid; both errors SHALL pulse together if both occur.
REQ-025 After STOP, SHALL go to IDLE if the stop bit = 1, else to WAIT_HIGH.
REQ-026 WAIT_HIGH SHALL stay until rx_s = 1, then go to IDLE (a break produces one stp_err only).
REQ-027 p_data SHALL hold its value until the next good frame; error frames SHALL NOT modify it.
REQ-028 rx_busy SHALL be registered and equal (state != IDLE).
REQ-029 A falling edge at or after stop-bit resolution SHALL be accepted as a new start bit with no lost cycle.

Reset
REQ-030 rst low SHALL immediately set: p_data = 0, data_valid = par_err = stp_err = rx_busy = 0, FSM = IDLE, edge_cnt = 0, bit counter = 0, synchronizer flops = 1.
REQ-031 rst asserted mid-frame SHALL discard the partial frame; after release, the first frame SHALL be detected only from a fresh falling edge.

Verification (DWIDTH = 8, OVS = 8)
REQ-032 SHALL cover: par_en = 0, frame 0xA5 at 8 clk/bit -> data_valid pulse once, p_data = 0xA5, no errors.
REQ-033 SHALL cover: par_en = 1, par_typ = 0, 0x03 with parity bit 0 -> p_data = 0x03; repeat with parity bit 1 -> par_err pulse, p_data stays 0x03.
REQ-034 SHALL cover: stop bit driven 0 for 40 cycles after 0x55 -> exactly one stp_err, no data_valid, rx_busy high until the line returns high.
REQ-035 SHALL cover: a 2-cycle low glitch on idle rx_in -> return to IDLE, no pulses, p_data unchanged.
REQ-036 SHALL cover: back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses with correct data.
REQ-037 SHALL cover: rst asserted mid-DATA, then a frame of 0x3C -> all outputs 0 during reset, then p_data = 0x3C with one data_valid pulse.
